// File: rtl/monitor_dbg_poller.sv
// rtl/monitor_dbg_poller.sv - Avalon-MM poller that reports changes of a debug PIO on a valid/ready stream
//
// Purpose: periodically reads the debug-data PIO, compares each sample with the
// previous one and forwards changed values (with a sequence number) through a
// one-deep output register. Changes that arrive while the register is full and
// not being drained are counted as drops.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            polling allowed
//   avm_address       constant PIO word address
//   avm_read          read request, held until accepted
//   avm_waitrequest   slave stall
//   avm_readdata      read data, low DATA_W bits used
//   out_valid/ready   change-record handshake
//   out_data, out_seq record payload and sequence number
//   drop_count        saturating count of records lost to back-pressure
//   busy              a poll transaction is in progress
module monitor_dbg_poller #(
  parameter int          DATA_W        = 16,
  parameter int          POLL_INTERVAL = 64,
  parameter int          READ_LATENCY  = 1,
  parameter logic [1:0]  PIO_ADDR      = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_seq,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_CMP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       drop_q, drop_d;

  logic change, pop, push, drop;

  // Poll sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    sample_d = sample_q;
    last_d   = last_q;
    first_d  = first_q;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        // lat_q counts down the remaining edges until readdata is valid
        if (lat_q == '0) begin
          sample_d = avm_readdata[DATA_W-1:0];
          state_d  = ST_CMP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: begin
        // last always follows the sample, even when the record is dropped
        last_d  = sample_q;
        first_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-deep output register with drop accounting
  always_comb begin
    change      = (state_q == ST_CMP) && (first_q || (sample_q != last_q));
    pop         = out_valid_q && out_ready;
    push        = change && (!out_valid_q || pop);
    drop        = change && out_valid_q && !out_ready;
    out_valid_d = push || (out_valid_q && !pop);
    out_data_d  = push ? sample_q : out_data_q;
    seq_d       = pop ? seq_q + 8'd1 : seq_q;
    drop_d      = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      sample_q    <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      seq_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      sample_q    <= sample_d;
      last_q      <= last_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
    end
  end

  // Upper readdata bits are deliberately ignored
  generate
    if (DATA_W < 32) begin : g_unused_rdata
      logic unused_rdata;
      assign unused_rdata = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  assign avm_address = PIO_ADDR;
  assign avm_read    = (state_q == ST_REQ);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_seq     = seq_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_monitor_dbg_poller.sv
// tb/tb_monitor_dbg_poller.sv - scoreboard bench for monitor_dbg_poller
module tb_monitor_dbg_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [7:0]  out_seq;
  logic [15:0] drop_count;
  logic        busy;

  logic [15:0] pio = 16'h0000;
  logic        acc = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  s;
  } rec_t;

  rec_t     exp_q[$];
  rec_t     mon_e;
  bit [7:0] exp_seq = 8'd0;

  monitor_dbg_poller #(
    .DATA_W(16), .POLL_INTERVAL(4), .READ_LATENCY(1), .PIO_ADDR(2'd0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_seq(out_seq), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO slave: data is valid only in the cycle after acceptance, garbage otherwise
  always @(posedge clk) acc <= avm_read && !avm_waitrequest;
  assign avm_readdata = acc ? {16'hA5A5, pio} : 32'h0000BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d);
    exp_q.push_back({d, exp_seq});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic wait_read();
    int n = 0;
    while (avm_read !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (avm_read !== 1'b1) chk("timeout_read", {31'd0, avm_read}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("timeout_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_poll(input logic [15:0] v);
    pio = v;
    wait_read();
    wait_idle();
  endtask

  // Monitor: pops the scoreboard on every accepted record
  always begin
    @(negedge clk);
    #1;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got data 0x%0h seq %0d expected none", out_data, out_seq);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_data", {16'd0, out_data}, {16'd0, mon_e.d});
        chk("rec_seq", {24'd0, out_seq}, {24'd0, mon_e.s});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_seq", {24'd0, out_seq}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("avm_address", {30'd0, avm_address}, 32'd0);

    // 1: first read 4 cycles after enable, first record seq 0
    pio = 16'h1234;
    push_exp(16'h1234);
    reset = 1'b0;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avm_read !== 1'b1 && n < 50);
    chk("first_read_latency", n, 32'd4);
    wait_idle();

    // 2: unchanged value produces nothing
    for (int i = 0; i < 10; i++) do_poll(16'h1234);
    chk("no_drop_unchanged", {16'd0, drop_count}, 32'd0);

    // 3: waitrequest stalls of 3 cycles
    for (int k = 0; k < 2; k++) begin
      logic [15:0] v;
      v = (k == 0) ? 16'h5555 : 16'h6666;
      pio = v;
      push_exp(v);
      avm_waitrequest = 1'b1;
      wait_read();
      n = 0;
      while (avm_read === 1'b1 && n < 50) begin
        n++;
        if (n == 4) avm_waitrequest = 1'b0;
        @(negedge clk);
      end
      avm_waitrequest = 1'b0;
      chk("read_hold_cycles", n, 32'd4);
      wait_idle();
    end
    repeat (2) @(negedge clk);

    // 4: back-pressure holds first change and drops the next two
    out_ready = 1'b0;
    push_exp(16'h0001);
    do_poll(16'h0001);
    do_poll(16'h0002);
    do_poll(16'h0003);
    chk("bp_drop_count", {16'd0, drop_count}, 32'd2);
    chk("bp_out_data", {16'd0, out_data}, 32'h0001);
    chk("bp_out_seq", {24'd0, out_seq}, 32'd3);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_seq_after", {24'd0, out_seq}, 32'd4);
    chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
    do_poll(16'h0003);
    repeat (2) @(negedge clk);

    // 5: push in the same cycle as pop
    out_ready = 1'b0;
    push_exp(16'h0010);
    do_poll(16'h0010);
    repeat (2) @(negedge clk);
    pio = 16'h0011;
    push_exp(16'h0011);
    wait_read();
    @(negedge clk);
    @(negedge clk);
    chk("cmp_state_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("nobubble_valid", {31'd0, out_valid}, 32'd1);
    chk("nobubble_data", {16'd0, out_data}, 32'h0011);
    chk("nobubble_seq", {24'd0, out_seq}, 32'd5);
    wait_idle();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      v = 16'h0100 + 16'(i);
      push_exp(v);
      do_poll(v);
    end
    repeat (3) @(negedge clk);
    chk("seq_wrap", {24'd0, out_seq}, 32'd50);

    // 6: reset during WAIT
    pio = 16'h7777;
    wait_read();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("wrst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("wrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("wrst_out_seq", {24'd0, out_seq}, 32'd0);
    chk("wrst_drop", {16'd0, drop_count}, 32'd0);
    chk("wrst_busy", {31'd0, busy}, 32'd0);
    exp_seq = 8'd0;
    reset = 1'b0;
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_data_ignored", {31'd0, out_valid}, 32'd0);
    chk("parked_idle", {31'd0, busy}, 32'd0);

    // first sample after reset is reported even when it is zero
    pio = 16'h0000;
    push_exp(16'h0000);
    enable = 1'b1;
    wait_read();
    wait_idle();
    repeat (2) @(negedge clk);

    // enable dropped mid-transaction: completes, then no further reads
    wait_read();
    enable = 1'b0;
    wait_idle();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (avm_read) n++;
    end
    chk("parked_no_reads", n, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
